// File: rtl/delay_line_ctrl.sv
// Per-sample echo engine driving a dual-port delay BRAM: read the delayed word,
// write input + feedback*delayed, emit input + mix*delayed.
module delay_line_ctrl #(
    parameter int T = 20000,
    parameter int B = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sample_valid,
    input  logic [31:0]   sample_in,
    input  logic [B-1:0]  delay_len,
    input  logic [7:0]    feedback,
    input  logic [7:0]    mix,
    output logic [31:0]   sample_out,
    output logic          out_valid,
    output logic          busy,
    output logic          dropped,
    output logic          mem_we,
    output logic [B-1:0]  mem_addr1,
    output logic [B-1:0]  mem_addr2,
    output logic [31:0]   mem_di,
    input  logic [31:0]   mem_do2
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_CALC = 2'd2;
    localparam logic [1:0] S_WR   = 2'd3;

    logic [1:0]         state;
    logic [B-1:0]       wr_ptr;
    logic [B-1:0]       d_clamp;
    logic [B-1:0]       rd_addr;
    logic [31:0]        x_r;
    logic [7:0]         fb_r;
    logic [7:0]         mix_r;
    logic signed [32:0] fbp_r;
    logic signed [32:0] wet_r;
    logic signed [32:0] fbp_next;
    logic signed [32:0] wet_next;
    logic [33:0]        sum_fb;
    logic [33:0]        sum_wet;
    logic [31:0]        sat_fb;
    logic [31:0]        sat_wet;
    logic [31:0]        mem_di_q;

    // Clamp to 34-bit sum into the signed 32-bit range.
    function automatic logic [31:0] sat32(input logic [33:0] s);
        if (!s[33] && (s[32:31] != 2'b00))
            return 32'h7FFF_FFFF;
        else if (s[33] && (s[32:31] != 2'b11))
            return 32'h8000_0000;
        else
            return s[31:0];
    endfunction

    // d >= 1 keeps the read off the slot being written this sample.
    always_comb begin
        d_clamp = delay_len;
        if (delay_len == '0)
            d_clamp = B'(1);
        else if (int'(delay_len) > T - 1)
            d_clamp = B'(T - 1);
        rd_addr = (wr_ptr >= d_clamp) ? (wr_ptr - d_clamp) : (wr_ptr + B'(T) - d_clamp);
    end

    // 41-bit signed products, arithmetic shift by 8 (Q0.8 gains).
    assign fbp_next = 33'(($signed({{9{mem_do2[31]}}, mem_do2}) * $signed({33'd0, fb_r})) >>> 8);
    assign wet_next = 33'(($signed({{9{mem_do2[31]}}, mem_do2}) * $signed({33'd0, mix_r})) >>> 8);

    assign sum_fb  = {{2{x_r[31]}}, x_r} + {fbp_r[32], fbp_r};
    assign sum_wet = {{2{x_r[31]}}, x_r} + {wet_r[32], wet_r};
    assign sat_fb  = sat32(sum_fb);
    assign sat_wet = sat32(sum_wet);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            mem_addr2  <= '0;
            sample_out <= '0;
            mem_di_q   <= '0;
            out_valid  <= 1'b0;
            dropped    <= 1'b0;
            x_r        <= '0;
            fb_r       <= '0;
            mix_r      <= '0;
            fbp_r      <= '0;
            wet_r      <= '0;
        end else begin
            out_valid <= 1'b0;
            dropped   <= sample_valid && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (sample_valid) begin
                        x_r       <= sample_in;
                        fb_r      <= feedback;
                        mix_r     <= mix;
                        mem_addr2 <= rd_addr;
                        state     <= S_RD;
                    end
                end
                S_RD: state <= S_CALC;
                S_CALC: begin
                    fbp_r <= fbp_next;
                    wet_r <= wet_next;
                    state <= S_WR;
                end
                S_WR: begin
                    mem_di_q   <= sat_fb;
                    sample_out <= sat_wet;
                    out_valid  <= 1'b1;
                    wr_ptr     <= (wr_ptr == B'(T - 1)) ? '0 : wr_ptr + B'(1);
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign mem_we    = (state == S_WR);
    assign mem_addr1 = wr_ptr;
    // Write data is live during WR and held afterwards.
    assign mem_di    = mem_we ? sat_fb : mem_di_q;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Bench for delay_line_ctrl: small BRAM model, circular-buffer reference model,
// directed echo/feedback/saturation/wrap/busy/reset cases plus randomized samples.
module tb_delay_line_ctrl;

    localparam int T = 8;
    localparam int B = 4;

    logic          clk;
    logic          rst;
    logic          sample_valid;
    logic [31:0]   sample_in;
    logic [B-1:0]  delay_len;
    logic [7:0]    feedback;
    logic [7:0]    mix;
    logic [31:0]   sample_out;
    logic          out_valid;
    logic          busy;
    logic          dropped;
    logic          mem_we;
    logic [B-1:0]  mem_addr1;
    logic [B-1:0]  mem_addr2;
    logic [31:0]   mem_di;
    logic [31:0]   mem_do2;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] bram    [0:(1<<B)-1] = '{default: 32'd0};
    logic [31:0] ref_buf [0:T-1]      = '{default: 32'd0};
    int          ref_ptr = 0;

    delay_line_ctrl #(.T(T), .B(B)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .delay_len    (delay_len),
        .feedback     (feedback),
        .mix          (mix),
        .sample_out   (sample_out),
        .out_valid    (out_valid),
        .busy         (busy),
        .dropped      (dropped),
        .mem_we       (mem_we),
        .mem_addr1    (mem_addr1),
        .mem_addr2    (mem_addr2),
        .mem_di       (mem_di),
        .mem_do2      (mem_do2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read dual-port BRAM
    always @(posedge clk) begin
        if (mem_we)
            bram[mem_addr1] <= mem_di;
        mem_do2 <= bram[mem_addr2];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat_ref(input longint v);
        if (v > 64'sd2147483647)
            return 32'h7FFF_FFFF;
        else if (v < -64'sd2147483648)
            return 32'h8000_0000;
        else
            return 32'(v);
    endfunction

    // scoreboard: every out_valid pops one expected output
    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0)
                check_eq("out_extra", exp_q.size(), 1);
            else
                check_eq("sample_out", sample_out, exp_q.pop_front());
        end
    end

    task automatic idle(input int n);
        sample_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One sample through the engine; drop_at (1..3) injects an ignored strobe
    task automatic run_sample(input logic [31:0] x, input logic [B-1:0] dl,
                              input logic [7:0] fb, input logic [7:0] mx, input int drop_at);
        int          d;
        int          rd;
        int          e_ptr;
        int          fbi;
        int          mxi;
        longint      y;
        longint      xs;
        logic [31:0] e_w;
        logic [31:0] e_out;
        d = int'(dl);
        if (d == 0) d = 1;
        if (d > T - 1) d = T - 1;
        rd    = (ref_ptr - d + T) % T;
        y     = longint'($signed(ref_buf[rd]));
        xs    = longint'($signed(x));
        fbi   = fb;
        mxi   = mx;
        e_w   = sat_ref(xs + ((y * fbi) >>> 8));
        e_out = sat_ref(xs + ((y * mxi) >>> 8));
        e_ptr = ref_ptr;
        ref_buf[ref_ptr] = e_w;
        ref_ptr = (ref_ptr + 1) % T;
        exp_q.push_back(e_out);

        sample_valid = 1'b1;
        sample_in    = x;
        delay_len    = dl;
        feedback     = fb;
        mix          = mx;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            #1;
            sample_valid = (c == drop_at);
            if (c == drop_at) begin
                sample_in = $urandom;
                delay_len = B'($urandom_range(0, 15));
                feedback  = 8'($urandom);
                mix       = 8'($urandom);
            end
            check_eq("busy", busy, c < 4);
            check_eq("dropped", dropped, (drop_at > 0) && (c == drop_at + 1));
            check_eq("mem_we", mem_we, c == 3);
            if (c == 1) check_eq("mem_addr2", mem_addr2, rd);
            if (c == 3) begin
                check_eq("mem_addr1", mem_addr1, e_ptr);
                check_eq("mem_di", mem_di, e_w);
            end
            if (c == 4) begin
                check_eq("out_valid", out_valid, 1);
                check_eq("mem_di_held", mem_di, e_w);
                check_eq("wr_ptr_next", mem_addr1, ref_ptr);
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        sample_valid = 1'b0;
        sample_in    = '0;
        delay_len    = '0;
        feedback     = '0;
        mix          = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_sample_out", sample_out, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_dropped", dropped, 0);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_mem_addr1", mem_addr1, 0);
        check_eq("rst_mem_addr2", mem_addr2, 0);
        check_eq("rst_mem_di", mem_di, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // impulse echo
        run_sample(32'h0010_0000, 4'd4, 8'd0, 8'd255, 0);
        for (int i = 0; i < 7; i++) run_sample(32'h0, 4'd4, 8'd0, 8'd255, 0);

        // decaying feedback
        run_sample(32'h0010_0000, 4'd2, 8'd128, 8'd0, 0);
        for (int i = 0; i < 7; i++) run_sample(32'h0, 4'd2, 8'd128, 8'd0, 0);

        // saturation both ways
        run_sample(32'h7FFF_FFF0, 4'd1, 8'd255, 8'd0, 0);
        run_sample(32'h7FFF_FFF0, 4'd1, 8'd255, 8'd0, 0);
        check_eq("sat_pos", mem_di, 32'h7FFF_FFFF);
        run_sample(32'h8000_0010, 4'd1, 8'd255, 8'd0, 0);
        run_sample(32'h8000_0010, 4'd1, 8'd255, 8'd0, 0);
        check_eq("sat_neg", mem_di, 32'h8000_0000);

        // pointer wrap and delay clamping
        for (int i = 0; i < 20; i++) run_sample($urandom, 4'd3, 8'($urandom), 8'($urandom), 0);
        for (int i = 0; i < 3; i++)  run_sample($urandom, 4'd0, 8'd200, 8'd100, 0);
        for (int i = 0; i < 3; i++)  run_sample($urandom, 4'd9, 8'd200, 8'd100, 0);

        // strobes while busy
        run_sample(32'h0123_4567, 4'd5, 8'd64, 8'd192, 2);
        run_sample(32'h7654_3210, 4'd5, 8'd64, 8'd192, 1);
        run_sample(32'hFEDC_BA98, 4'd5, 8'd64, 8'd192, 3);

        // reset during WR aborts the sample
        sample_valid = 1'b1;
        sample_in    = 32'h1111_1111;
        delay_len    = 4'd2;
        feedback     = 8'd10;
        mix          = 8'd20;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            #1;
            sample_valid = 1'b0;
        end
        check_eq("abort_pre_we", mem_we, 1);
        rst = 1'b1;
        #1;
        check_eq("abort_mem_we", mem_we, 0);
        check_eq("abort_out_valid", out_valid, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_wr_ptr", mem_addr1, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ref_ptr = 0;
        @(posedge clk);
        #1;
        run_sample(32'h0000_4000, 4'd3, 8'd100, 8'd150, 0);

        // randomized
        for (int i = 0; i < 60; i++) begin
            logic [31:0] rx;
            case ($urandom_range(0, 3))
                0:       rx = 32'h7FF0_0000 | 32'($urandom_range(0, 65535));
                1:       rx = 32'h8000_0000 | 32'($urandom_range(0, 65535));
                default: rx = $urandom;
            endcase
            run_sample(rx, B'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
                       int'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end

        idle(3);
        check_eq("exp_q_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
